// File: rtl/localbus_master.sv
// Localbus initiator: turns single read/write commands into ALE/CS_N bus cycles
// toward a UM slave, with bounded ack waits, a one-cycle response and statistics.
module localbus_master #(
  parameter int ALE_CYCLES = 1,
  parameter int GAP_CYCLES = 1,
  parameter int TIMEOUT    = 255,
  parameter int width_cnt  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic                 cmd_wr,
  input  logic [31:0]          cmd_addr,
  input  logic [31:0]          cmd_wdata,
  output logic                 cmd_ready,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 localbus_cs_n,
  output logic                 localbus_rd_wr,
  output logic [31:0]          localbus_data,
  output logic                 localbus_ale,
  input  logic                 localbus_ack_n,
  input  logic [31:0]          localbus_data_out,
  output logic [width_cnt-1:0] txn_cnt,
  output logic [width_cnt-1:0] timeout_cnt
);

  typedef enum logic [2:0] {IDLE, ADDR, GAP, ACC, REL, RESP} state_t;

  localparam logic [15:0] ALE_LAST = 16'(ALE_CYCLES - 1);
  localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  state_t               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic                 wr_q, wr_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 to_q, to_d;

  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_timeout_q, rsp_timeout_d;
  logic                 cs_n_q, cs_n_d;
  logic                 ale_q, ale_d;
  logic                 rd_wr_q, rd_wr_d;
  logic [31:0]          bus_data_q, bus_data_d;
  logic [width_cnt-1:0] txn_cnt_q, txn_cnt_d;
  logic [width_cnt-1:0] timeout_cnt_q, timeout_cnt_d;

  // Sequencing: one counter is reused for ALE hold, gap, ack wait and release wait.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    to_d    = to_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          wr_d    = cmd_wr;
          addr_d  = cmd_addr;
          wdata_d = cmd_wdata;
          rdata_d = '0;
          to_d    = 1'b0;
          cnt_d   = '0;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (cnt_q == ALE_LAST) begin
          cnt_d   = '0;
          state_d = (GAP_CYCLES == 0) ? ACC : GAP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d   = '0;
          state_d = ACC;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ACC: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (!localbus_ack_n) begin
          if (!wr_q) rdata_d = localbus_data_out;
          cnt_d   = '0;
          state_d = REL;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          cnt_d   = '0;
          state_d = REL;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      REL: begin
        if (localbus_ack_n) begin
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          to_d    = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_comb begin
    cmd_ready_d = (state_d == IDLE);
    ale_d       = 1'b0;
    cs_n_d      = 1'b1;
    rd_wr_d     = 1'b1;
    bus_data_d  = '0;
    unique case (state_d)
      ADDR: begin
        ale_d      = 1'b1;
        bus_data_d = addr_d;
        rd_wr_d    = ~wr_d;
      end
      GAP: rd_wr_d = ~wr_d;
      ACC: begin
        cs_n_d     = 1'b0;
        rd_wr_d    = ~wr_d;
        bus_data_d = wr_d ? wdata_d : 32'h0;
      end
      default: ;
    endcase

    rsp_valid_d   = (state_d == RESP);
    rsp_timeout_d = rsp_valid_d && to_d;
    rsp_rdata_d   = (rsp_valid_d && !to_d && !wr_d) ? rdata_d : 32'h0;

    txn_cnt_d     = txn_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    if (rsp_valid_d) begin
      txn_cnt_d = txn_cnt_q + width_cnt'(1);
      if (to_d && (timeout_cnt_q != '1)) timeout_cnt_d = timeout_cnt_q + width_cnt'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      rdata_q       <= '0;
      to_q          <= 1'b0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      cs_n_q        <= 1'b1;
      ale_q         <= 1'b0;
      rd_wr_q       <= 1'b1;
      bus_data_q    <= '0;
      txn_cnt_q     <= '0;
      timeout_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      wr_q          <= wr_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      rdata_q       <= rdata_d;
      to_q          <= to_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      cs_n_q        <= cs_n_d;
      ale_q         <= ale_d;
      rd_wr_q       <= rd_wr_d;
      bus_data_q    <= bus_data_d;
      txn_cnt_q     <= txn_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign localbus_cs_n  = cs_n_q;
  assign localbus_ale   = ale_q;
  assign localbus_rd_wr = rd_wr_q;
  assign localbus_data  = bus_data_q;
  assign txn_cnt        = txn_cnt_q;
  assign timeout_cnt    = timeout_cnt_q;

endmodule

// File: tb/tb_localbus_master.sv
// Randomized scoreboard bench for localbus_master: a behavioural slave answers the
// bus, a transaction-level model predicts each response, a monitor compares.
module tb_localbus_master;
  localparam int ALE_CYCLES = 1;
  localparam int GAP_CYCLES = 1;
  localparam int TIMEOUT    = 8;
  localparam int CW         = 16;
  localparam int CMAX       = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0, cmd_wr = 1'b0;
  logic [31:0]   cmd_addr = '0, cmd_wdata = '0;
  logic          cmd_ready, rsp_valid, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic          localbus_cs_n, localbus_rd_wr, localbus_ale;
  logic [31:0]   localbus_data;
  logic          localbus_ack_n = 1'b1;
  logic [31:0]   localbus_data_out = '0;
  logic [CW-1:0] txn_cnt, timeout_cnt;

  localbus_master #(
    .ALE_CYCLES(ALE_CYCLES), .GAP_CYCLES(GAP_CYCLES), .TIMEOUT(TIMEOUT), .width_cnt(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ready(cmd_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .localbus_cs_n(localbus_cs_n), .localbus_rd_wr(localbus_rd_wr), .localbus_data(localbus_data),
    .localbus_ale(localbus_ale), .localbus_ack_n(localbus_ack_n), .localbus_data_out(localbus_data_out),
    .txn_cnt(txn_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  // d: ACC cycle index at which the slave pulls ack low (>= TIMEOUT means never).
  // h: number of REL cycles the slave keeps ack low after acking.
  typedef struct {
    bit          wr;
    logic [31:0] addr, wdata, sdata;
    int          d, h;
  } txn_t;

  typedef struct {
    txn_t        t;
    int          acc;
    bit          to;
    logic [31:0] rdata;
    int          cs, rel;
  } exp_t;

  exp_t exp_q[$];
  txn_t slave_q[$];
  int   n_cmp = 0, n_bad = 0, n_rsp = 0, cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t model(input txn_t t, input int c);
    exp_t e;
    e.t   = t;
    e.acc = c;
    if (t.d >= TIMEOUT) begin
      e.to  = 1'b1;
      e.cs  = TIMEOUT;
      e.rel = 1;
    end else begin
      e.cs  = t.d + 1;
      e.to  = (t.h >= TIMEOUT);
      e.rel = e.to ? TIMEOUT : t.h + 1;
    end
    e.rdata = (t.wr || e.to) ? 32'h0 : t.sdata;
    return e;
  endfunction

  function automatic txn_t mk(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] sd, input int d, input int h);
    txn_t t;
    t.wr = wr; t.addr = a; t.wdata = wd; t.sdata = sd; t.d = d; t.h = h;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    txn_t t;
    t.wr    = 1'($urandom_range(0, 1));
    t.addr  = $urandom;
    t.wdata = $urandom;
    t.sdata = $urandom;
    t.d     = ($urandom_range(0, 5) == 0) ? TIMEOUT + int'($urandom_range(0, 3))
                                          : int'($urandom_range(0, TIMEOUT - 1));
    t.h     = ($urandom_range(0, 6) == 0) ? TIMEOUT - 1 + int'($urandom_range(0, 4))
                                          : int'($urandom_range(0, 3));
    return t;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Behavioural slave: reacts at the falling edge so its ack is seen by the same cycle's rising edge.
  initial begin : slave
    txn_t cur;
    int   sst = 0, k = 0, j = 0;
    bit   acked = 1'b0;
    cur = mk(1'b0, 32'h0, 32'h0, 32'h0, 1000, 0);
    forever begin
      @(negedge clk);
      if (!reset) begin
        sst = 0;
        localbus_ack_n = 1'b1;
      end else begin
        if (!localbus_cs_n && sst != 1) begin
          sst = 1; k = 0; acked = 1'b0;
          if (slave_q.size() > 0) cur = slave_q.pop_front();
          else cur = mk(1'b0, 32'h0, 32'h0, 32'h0, 1000, 0);
        end else if (localbus_cs_n && sst == 1) begin
          sst = 2; j = 0;
        end
        case (sst)
          1: begin
            if (k >= cur.d) begin
              localbus_ack_n = 1'b0; localbus_data_out = cur.sdata; acked = 1'b1;
            end else begin
              localbus_ack_n = 1'b1; localbus_data_out = $urandom;
            end
            k++;
          end
          2: begin
            if (acked && j < cur.h) localbus_ack_n = 1'b0;
            else begin
              localbus_ack_n = 1'b1; sst = 0;
            end
            localbus_data_out = $urandom;
            j++;
          end
          default: begin
            localbus_ack_n    = 1'($urandom_range(0, 1));
            localbus_data_out = $urandom;
          end
        endcase
      end
    end
  end

  // Monitor: tracks bus phases of the in-flight transaction and scores each response.
  initial begin : monitor
    exp_t cur_e, e;
    int   ph = 0, ale_cnt = 0, gap_cnt = 0, cs_cnt = 0, rel_cnt = 0, m_txn = 0, m_to = 0;
    bit   bad = 1'b0, prev_rsp = 1'b0;
    cur_e = model(mk(1'b0, 32'h0, 32'h0, 32'h0, 0, 0), 0);
    forever begin
      @(negedge clk);
      if (!reset) begin
        ph = 0; ale_cnt = 0; gap_cnt = 0; cs_cnt = 0; rel_cnt = 0;
        bad = 1'b0; prev_rsp = 1'b0; m_txn = 0; m_to = 0;
      end else begin
        if (prev_rsp) check("ready_after_rsp", 64'(cmd_ready), 64'd1);
        if (exp_q.size() > 0) cur_e = exp_q[0];
        if (localbus_ale) begin
          ale_cnt++; ph = 1;
          if (localbus_data !== cur_e.t.addr || localbus_rd_wr !== !cur_e.t.wr || localbus_cs_n !== 1'b1) bad = 1'b1;
        end else if (!localbus_cs_n) begin
          cs_cnt++; ph = 2;
          if (localbus_data !== (cur_e.t.wr ? cur_e.t.wdata : 32'h0) || localbus_rd_wr !== !cur_e.t.wr) bad = 1'b1;
        end else begin
          if (localbus_data !== 32'h0) bad = 1'b1;
          if (ph == 1) begin
            gap_cnt++;
            if (localbus_rd_wr !== !cur_e.t.wr) bad = 1'b1;
          end else begin
            if (localbus_rd_wr !== 1'b1) bad = 1'b1;
            if (ph == 2 && !rsp_valid) rel_cnt++;
          end
        end
        if ((ph != 0 || rsp_valid) && cmd_ready) bad = 1'b1;
        if (rsp_valid) begin
          n_rsp++;
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_rsp: got rsp_valid=1, required no response (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            m_txn++;
            if (e.to && m_to < CMAX) m_to++;
            check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
            check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
            check("latency", 64'(cyc - e.acc), 64'(ALE_CYCLES + GAP_CYCLES + e.cs + e.rel + 1));
            check("ale_cycles", 64'(ale_cnt), 64'(ALE_CYCLES));
            check("gap_cycles", 64'(gap_cnt), 64'(GAP_CYCLES));
            check("cs_low_cycles", 64'(cs_cnt), 64'(e.cs));
            check("rel_cycles", 64'(rel_cnt), 64'(e.rel));
            check("bus_protocol", 64'(bad), 64'd0);
            check("txn_cnt", 64'(txn_cnt), 64'(CW'(m_txn)));
            check("timeout_cnt", 64'(timeout_cnt), 64'(m_to));
          end
          ph = 0; ale_cnt = 0; gap_cnt = 0; cs_cnt = 0; rel_cnt = 0; bad = 1'b0;
        end
        prev_rsp = rsp_valid;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the accept cycle.
  task automatic issue(input txn_t t, input bit hold);
    int g = 0;
    cmd_valid = 1'b1; cmd_wr = t.wr; cmd_addr = t.addr; cmd_wdata = t.wdata;
    while (!cmd_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_wait: got cmd_ready=0 for %0d cycles, required 1", g);
      cmd_valid = 1'b0;
      return;
    end
    exp_q.push_back(model(t, cyc));
    slave_q.push_back(t);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while (exp_q.size() > 0 && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (exp_q.size() > 0) begin
      n_cmp++; n_bad++;
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin : stim
    int g, rsp_before;
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cs_n", 64'(localbus_cs_n), 64'd1);
    check("rst_ale", 64'(localbus_ale), 64'd0);
    check("rst_rd_wr", 64'(localbus_rd_wr), 64'd1);
    check("rst_data", 64'(localbus_data), 64'd0);
    check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
    check("rst_txn_cnt", 64'(txn_cnt), 64'd0);
    check("rst_timeout_cnt", 64'(timeout_cnt), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(cmd_ready), 64'd1);

    issue(mk(1'b1, 32'h10, 32'hA5A5A5A5, 32'hDEADBEEF, 2, 0), 1'b0);
    drain();
    issue(mk(1'b0, 32'h20, 32'h0, 32'h12345678, 0, 0), 1'b0);
    drain();
    issue(mk(1'b0, 32'h30, 32'h0, 32'hCAFEF00D, TIMEOUT + 10, 0), 1'b0);
    drain();
    issue(mk(1'b0, 32'h40, 32'h0, 32'h0BADF00D, 1, 300), 1'b0);
    drain();
    issue(mk(1'b1, 32'h44, 32'h5A5A0001, 32'h0, 0, 0), 1'b0);
    drain();
    for (int i = 0; i < 3; i++)
      issue(mk(1'b0, 32'h100 + 32'(i), 32'h0, 32'h1000 + 32'(i), i, 0), i < 2);
    drain();

    for (int i = 0; i < 60; i++) begin
      issue(rnd_txn(), 1'b0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // Abort in the middle of an access: no response may follow.
    issue(mk(1'b0, 32'h80, 32'h0, 32'h0, TIMEOUT + 10, 0), 1'b0);
    g = 0;
    while (localbus_cs_n && g < 100) begin
      @(negedge clk);
      g++;
    end
    check("reached_acc", 64'(localbus_cs_n), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_cs_n", 64'(localbus_cs_n), 64'd1);
    check("abort_ale", 64'(localbus_ale), 64'd0);
    check("abort_rd_wr", 64'(localbus_rd_wr), 64'd1);
    check("abort_data", 64'(localbus_data), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
    check("abort_txn_cnt", 64'(txn_cnt), 64'd0);
    check("abort_timeout_cnt", 64'(timeout_cnt), 64'd0);
    exp_q.delete();
    slave_q.delete();
    rsp_before = n_rsp;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("ready_post_abort", 64'(cmd_ready), 64'd1);
    repeat (20) @(negedge clk);
    check("no_rsp_after_abort", 64'(n_rsp), 64'(rsp_before));

    issue(mk(1'b0, 32'h90, 32'h0, 32'h600DD00D, 1, 1), 1'b0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/localbus_master.md
Name: localbus_master

Overview:
- Host-side initiator for the UM localbus register interface: converts single read/write commands into ALE/CS_N localbus transactions toward the UM slave ports and returns completion responses.
- Sits between the management command source (CPU bridge / test sequencer) and the UM localbus_* ports.
- Adds a bounded-wait timeout, response reporting, and transaction/timeout statistics.

Parameters:
- ALE_CYCLES, 1, cycles ALE is held high with the address driven (1..15).
- GAP_CYCLES, 1, idle cycles between ALE falling and CS_N asserting (0..15).
- TIMEOUT, 255, max cycles waited for ack_n low, and separately for ack_n high after release (1..65535).
- width_cnt, 16, width of the statistics counters.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_wr  in  1  1 = write, 0 = read
- cmd_addr  in  32  register address
- cmd_wdata  in  32  write data
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  read data; 0 for writes and timeouts
- rsp_timeout  out  1  valid with rsp_valid; transaction timed out
- localbus_cs_n  out  1  chip select, active low
- localbus_rd_wr  out  1  1 = read, 0 = write
- localbus_data  out  32  address during ALE, write data during CS
- localbus_ale  out  1  address latch enable
- localbus_ack_n  in  1  slave acknowledge, active low
- localbus_data_out  in  32  slave read data
- txn_cnt  out  width_cnt  completed transactions, wraps
- timeout_cnt  out  width_cnt  timed-out transactions, saturates at all-ones

Behaviour:
- Reset values (asynchronous on reset=0, all states):
  - cs_n=1, ale=0, rd_wr=1, localbus_data=0
  - cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_timeout=0
  - both counters = 0, FSM = IDLE
- Reset mid-transaction aborts the transaction with no response. The bus returns to idle levels immediately.
- All outputs are registered. States: IDLE, ADDR, GAP, ACC, REL, RESP.
- IDLE:
  - cmd_ready=1, bus idle.
  - On cmd_valid & cmd_ready, latch wr/addr/wdata and go to ADDR; cmd_ready drops the next cycle.
- ADDR:
  - ale=1, localbus_data=addr, rd_wr=~wr, cs_n=1, held for ALE_CYCLES.
  - Then go to GAP, or to ACC if GAP_CYCLES=0.
- GAP: ale=0, data=0, rd_wr held, for GAP_CYCLES.
- ACC:
  - cs_n=0, rd_wr held; localbus_data=wdata for writes, 0 for reads.
  - Sample ack_n each cycle. On the first ack_n=0, capture localbus_data_out (reads only) and go to REL.
  - If the wait counter reaches TIMEOUT with ack_n still 1, set the timeout flag and go to REL.
- REL:
  - cs_n=1, data=0, rd_wr=1.
  - Wait for ack_n=1, bounded by a fresh TIMEOUT count. Overrun also sets the timeout flag.
  - Then go to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle with rsp_rdata/rsp_timeout.
  - txn_cnt += 1 (wraps). timeout_cnt += 1 if timeout, saturating.
  - Next state IDLE.
- rsp_valid has no backpressure. rsp_rdata is forced to 0 on timeout and for writes.
- ack_n=0 already present on ACC entry is accepted in that first ACC cycle.
- ack_n changes outside ACC/REL are ignored.
- Minimum transaction (ALE_CYCLES=1, GAP_CYCLES=1, ack in first ACC cycle, ack_n already high in REL):
  - accept at T0; ADDR at T1; GAP at T2; ACC at T3; REL at T4; rsp_valid at T5; cmd_ready again at T6.
- Exactly one transaction outstanding; back-to-back commands are separated by the IDLE cycle.

Test Plan:
- Write: cmd_wr=1, addr=0x00000010, wdata=0xA5A5A5A5, slave acks 2 cycles after CS low -> ALE with 0x10, rd_wr=0, data=0xA5A5A5A5 during CS; rsp_valid pulse, rsp_rdata=0, rsp_timeout=0, txn_cnt=1.
- Read: addr=0x20, slave returns 0x12345678 with ack_n=0 at first ACC cycle -> rsp_rdata=0x12345678 at T5, rd_wr=1 throughout, cs_n low exactly 1 cycle.
- Timeout: TIMEOUT=8, ack_n stuck high -> cs_n low 8 cycles, then release; rsp_timeout=1, rsp_rdata=0, timeout_cnt=1, txn_cnt=1.
- Stuck-low ack: ack_n held 0 through REL for 300 cycles, TIMEOUT=255 -> response after 255 REL cycles with rsp_timeout=1; next command still accepted.
- Reset mid-ACC: reset=0 while cs_n=0 -> cs_n=1, ale=0, rsp_valid=0, counters=0 immediately; no response after reset release; cmd_ready=1 in the first post-reset IDLE cycle.
- Back-to-back: cmd_valid held high for 3 reads -> exactly 3 rsp_valid pulses, one ADDR/ACC sequence per command, cmd_ready low between accept and RESP+1, txn_cnt=3.
